// File: rtl/bundle_slot_queue.sv
// Holds the remaining-valid slot mask of the current fetch bundle and hands
// slots to the instruction queue in order, bounded by IQ room and taken branches.
module bundle_slot_queue #(
    parameter int QSLOTS = 4,
    parameter int CNTW   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              phit,
    input  logic              next,
    input  logic [QSLOTS-1:0] ld_mask,
    input  logic [QSLOTS-1:0] ld_taken,
    input  logic              flush,
    input  logic [CNTW-1:0]   iq_room,
    output logic [QSLOTS-1:0] slotv,
    output logic [QSLOTS-1:0] queue,
    output logic [CNTW-1:0]   qcnt,
    output logic              redirect
);

    localparam logic [CNTW-1:0] MAX_ROOM = CNTW'(QSLOTS);

    logic [QSLOTS-1:0] taken_r;
    logic [CNTW-1:0]   room;
    logic [CNTW-1:0]   picked;
    logic              taken_pick;
    logic              stop;
    logic              load;

    assign room = (iq_room > MAX_ROOM) ? MAX_ROOM : iq_room;

    // A new bundle is only accepted once the current one has fully drained.
    assign load = next && phit && (slotv == '0);

    // NOTE: every variable written here gets a default first, so no latch is
    // inferred on paths where the scan picks nothing.
    always_comb begin
        queue      = '0;
        picked     = '0;
        taken_pick = 1'b0;
        stop       = 1'b0;
        if (!flush) begin
            for (int i = 0; i < QSLOTS; i++) begin
                if (!stop && slotv[i] && (picked < room)) begin
                    queue[i] = 1'b1;
                    picked   = picked + CNTW'(1);
                    if (taken_r[i]) begin
                        taken_pick = 1'b1;
                        stop       = 1'b1;
                    end
                end
            end
        end
    end

    assign qcnt = picked;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotv    <= '0;
            taken_r  <= '0;
            redirect <= 1'b0;
        end else if (flush) begin
            slotv    <= '0;
            taken_r  <= '0;
            redirect <= 1'b0;
        end else if (load) begin
            slotv    <= ld_mask;
            taken_r  <= ld_taken & ld_mask;
            redirect <= 1'b0;
        end else if (taken_pick) begin
            // Slots above the predicted-taken branch are on the wrong path.
            slotv    <= '0;
            taken_r  <= '0;
            redirect <= 1'b1;
        end else begin
            slotv    <= slotv & ~queue;
            taken_r  <= taken_r & ~queue;
            redirect <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bundle_slot_queue.sv
// Randomized bench for bundle_slot_queue against a slot-list reference model
// (pending slot indices kept in a queue, drained from the front).
module tb_bundle_slot_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       phit;
    logic       next;
    logic [3:0] ld_mask;
    logic [3:0] ld_taken;
    logic       flush;
    logic [2:0] iq_room;
    logic [3:0] slotv;
    logic [3:0] queue;
    logic [2:0] qcnt;
    logic       redirect;

    int n_vec = 0;
    int n_err = 0;

    int pend[$];
    bit tk[4];
    bit m_red;

    bundle_slot_queue #(.QSLOTS(4), .CNTW(3)) dut (
        .clk(clk), .rst_n(rst_n), .phit(phit), .next(next),
        .ld_mask(ld_mask), .ld_taken(ld_taken), .flush(flush),
        .iq_room(iq_room), .slotv(slotv), .queue(queue),
        .qcnt(qcnt), .redirect(redirect)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] pend_mask();
        logic [3:0] m = '0;
        foreach (pend[k]) m[pend[k]] = 1'b1;
        return m;
    endfunction

    task automatic model_clear();
        pend.delete();
        foreach (tk[k]) tk[k] = 1'b0;
        m_red = 1'b0;
    endtask

    // Expected picks: the first min(iq_room,4) pending slots, cut after a taken one.
    task automatic model_eval(output logic [3:0] q, output int n, output bit br);
        int lim = (iq_room > 4) ? 4 : int'(iq_room);
        q = '0; n = 0; br = 1'b0;
        if (flush) return;
        foreach (pend[k]) begin
            if (n >= lim || br) break;
            q[pend[k]] = 1'b1;
            n++;
            if (tk[pend[k]]) br = 1'b1;
        end
    endtask

    task automatic cycle();
        logic [3:0] eq;
        int         en;
        bit         br;
        int         new_pend[$];
        bit         new_tk[4];
        bit         new_red;
        #1;
        model_eval(eq, en, br);
        check("slotv", 32'(slotv), 32'(pend_mask()));
        check("queue", 32'(queue), 32'(eq));
        check("qcnt", 32'(qcnt), 32'(en));
        check("redirect", 32'(redirect), 32'(m_red));
        new_pend = pend;
        new_tk = tk;
        new_red = 1'b0;
        if (flush) begin
            new_pend.delete();
            foreach (new_tk[k]) new_tk[k] = 1'b0;
        end else if (next && phit && pend.size() == 0) begin
            for (int i = 0; i < 4; i++) begin
                if (ld_mask[i]) new_pend.push_back(i);
                new_tk[i] = ld_mask[i] & ld_taken[i];
            end
        end else if (br) begin
            new_pend.delete();
            foreach (new_tk[k]) new_tk[k] = 1'b0;
            new_red = 1'b1;
        end else begin
            for (int i = 0; i < en; i++) void'(new_pend.pop_front());
        end
        @(posedge clk);
        pend = new_pend;
        tk = new_tk;
        m_red = new_red;
        #1;
    endtask

    task automatic drive(input bit nx, input bit ph, input logic [3:0] m,
                         input logic [3:0] t, input bit fl, input logic [2:0] rm);
        next = nx; phit = ph; ld_mask = m; ld_taken = t; flush = fl; iq_room = rm;
        cycle();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset();
        rst_n = 1'b0;
        model_clear();
        #2;
        check("rst_slotv", 32'(slotv), 32'(0));
        check("rst_queue", 32'(queue), 32'(0));
        check("rst_redirect", 32'(redirect), 32'(0));
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; next = 0; phit = 0; ld_mask = '0; ld_taken = '0;
        flush = 0; iq_room = 3'd4;
        model_clear();
        #1;
        check("init_slotv", 32'(slotv), 32'(0));
        check("init_queue", 32'(queue), 32'(0));
        #11 rst_n = 1'b1;

        // Full bundle held with no room, then reset between edges.
        drive(1, 1, 4'b1111, 4'b0000, 0, 3'd0);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd0);
        mid_reset();

        // Drain 1111 at two per cycle.
        drive(1, 1, 4'b1111, 4'b0000, 0, 3'd2);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd2);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd2);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd2);

        // Saturated room drains a sparse bundle in one cycle.
        drive(1, 1, 4'b1011, 4'b0000, 0, 3'd7);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd7);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd7);

        // Taken branch in slot 1 truncates the bundle and pulses redirect.
        drive(1, 1, 4'b1111, 4'b0010, 0, 3'd4);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd4);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd4);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd4);

        // Flush with slots pending, and zero room holding state.
        drive(1, 1, 4'b1111, 4'b0000, 0, 3'd2);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd2);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd0);
        drive(0, 0, 4'b0000, 4'b0000, 1, 3'd4);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd4);

        // Load request while not empty is ignored.
        drive(1, 1, 4'b0100, 4'b0000, 0, 3'd0);
        drive(1, 1, 4'b1111, 4'b0000, 0, 3'd0);
        drive(1, 1, 4'b1111, 4'b0000, 0, 3'd4);
        drive(0, 0, 4'b0000, 4'b0000, 0, 3'd4);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) mid_reset();
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                  1'($urandom_range(0, 24) == 0), 3'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
